// File: rtl/twinkle_pkg.sv
// Shared definitions for the twinkle sequencer: FSM encoding, palette colours
// and the field layout of the incoming random word.
package twinkle_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEED   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int THR_LSB = 0;
   localparam int IDX_LSB = 8;
   localparam int PAL_LSB = 16;

   // Palette entries are stored as {R,G,B}; the serializer wants {G,R,B}.
   localparam logic [23:0] PAL_WARM_WHITE = 24'hFF_B0_60;
   localparam logic [23:0] PAL_RED        = 24'hFF_00_00;
   localparam logic [23:0] PAL_GREEN      = 24'h00_FF_00;
   localparam logic [23:0] PAL_GOLD       = 24'hFF_C0_00;

   function automatic logic [23:0] pal_rgb(input logic [1:0] pal);
      logic [23:0] rgb;
      case (pal)
         2'd0:    rgb = PAL_WARM_WHITE;
         2'd1:    rgb = PAL_RED;
         2'd2:    rgb = PAL_GREEN;
         default: rgb = PAL_GOLD;
      endcase
      return rgb;
   endfunction

endpackage

// File: rtl/twinkle_scale.sv
// Combinational colour scaler: palette colour times brightness, >>8 per
// channel, returned in WS2812 {G,R,B} order.
module twinkle_scale
   import twinkle_pkg::*;
(
   input  logic [1:0]  pal,
   input  logic [7:0]  bright,
   output logic [23:0] grb
);

   logic [23:0] rgb;
   logic [15:0] r_m;
   logic [15:0] g_m;
   logic [15:0] b_m;

   always_comb begin
      rgb = pal_rgb(pal);
      r_m = 16'(rgb[23:16]) * 16'(bright);
      g_m = 16'(rgb[15:8])  * 16'(bright);
      b_m = 16'(rgb[7:0])   * 16'(bright);
      grb = {g_m[15:8], r_m[15:8], b_m[15:8]};
   end

endmodule

// File: rtl/twinkle_sequencer.sv
// Per-frame twinkle engine: takes one random word, maybe ignites an LED, then
// streams one faded GRB pixel per LED over valid/ready.
module twinkle_sequencer
   import twinkle_pkg::*;
#(
   parameter int NB_LEDS     = 32,
   parameter int IDX_W       = 8,
   parameter int DECAY_SHIFT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [7:0]  cfg_density,
   input  logic        frame_start,
   input  logic        rnd_valid,
   input  logic [31:0] rnd_data,
   output logic        rnd_ready,
   output logic        pixel_valid,
   output logic [23:0] pixel_data,
   output logic        pixel_last,
   input  logic        pixel_ready,
   output logic        busy,
   output logic        frame_done
);

   localparam int                 LW         = (NB_LEDS > 1) ? $clog2(NB_LEDS) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NB_LEDS - 1);
   localparam logic [IDX_W:0]     NB_LEDS_W  = (IDX_W + 1)'(NB_LEDS);
   localparam logic [7:0]         DECAY_MIN  = 8'(1 << DECAY_SHIFT);

   function automatic logic [7:0] decay(input logic [7:0] b);
      return (b < DECAY_MIN) ? 8'd0 : b - (b >> DECAY_SHIFT);
   endfunction

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  led_q, led_d;
   logic [7:0]        bright_q [NB_LEDS];
   logic [7:0]        bright_d [NB_LEDS];
   logic [1:0]        pal_q    [NB_LEDS];
   logic [1:0]        pal_d    [NB_LEDS];
   logic              rnd_ready_q, rnd_ready_d;
   logic              pixel_valid_q, pixel_valid_d;
   logic [23:0]       pixel_data_q, pixel_data_d;
   logic              pixel_last_q, pixel_last_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;

   logic [7:0]        thr;
   logic [IDX_W-1:0]  idx;
   logic [1:0]        pal_in;
   logic [LW-1:0]     idx_sel;
   logic              ignite;
   logic [IDX_W-1:0]  led_nxt;
   logic [LW-1:0]     led_sel;
   logic [LW-1:0]     nxt_sel;
   logic              led_is_last;
   logic [1:0]        scl_pal;
   logic [7:0]        scl_b;
   logic [23:0]       scl_grb;
   logic              unused_rnd;

   assign thr         = rnd_data[THR_LSB +: 8];
   assign idx         = rnd_data[IDX_LSB +: IDX_W];
   assign pal_in      = rnd_data[PAL_LSB +: 2];
   assign idx_sel     = idx[LW-1:0];
   assign ignite      = (thr < cfg_density) && ({1'b0, idx} < NB_LEDS_W);
   assign unused_rnd  = ^rnd_data;

   assign led_nxt     = led_q + IDX_W'(1);
   assign led_sel     = led_q[LW-1:0];
   assign led_is_last = (led_q == LAST_IDX);
   assign nxt_sel     = led_is_last ? '0 : led_nxt[LW-1:0];

   // The pixel registered at an edge is the one for the LED presented next, so
   // in SEED it must already see a same-edge ignition of LED 0.
   always_comb begin
      scl_pal = pal_q[nxt_sel];
      scl_b   = bright_q[nxt_sel];
      if (state_q == ST_SEED) begin
         if (ignite && (idx == '0)) begin
            scl_pal = pal_in;
            scl_b   = 8'hFF;
         end else begin
            scl_pal = pal_q[0];
            scl_b   = bright_q[0];
         end
      end
   end

   twinkle_scale u_scale (
      .pal    (scl_pal),
      .bright (scl_b),
      .grb    (scl_grb)
   );

   always_comb begin
      state_d       = state_q;
      led_d         = led_q;
      bright_d      = bright_q;
      pal_d         = pal_q;
      rnd_ready_d   = 1'b0;
      pixel_valid_d = 1'b0;
      pixel_data_d  = pixel_data_q;
      pixel_last_d  = 1'b0;
      frame_done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (frame_start && enable) begin
               state_d     = ST_SEED;
               rnd_ready_d = 1'b1;
            end
         end
         ST_SEED: begin
            rnd_ready_d = 1'b1;
            if (rnd_valid) begin
               rnd_ready_d = 1'b0;
               if (ignite) begin
                  bright_d[idx_sel] = 8'hFF;
                  pal_d[idx_sel]    = pal_in;
               end
               led_d         = '0;
               pixel_valid_d = 1'b1;
               pixel_data_d  = scl_grb;
               pixel_last_d  = (LAST_IDX == '0);
               state_d       = ST_STREAM;
            end
         end
         ST_STREAM: begin
            pixel_valid_d = 1'b1;
            pixel_last_d  = pixel_last_q;
            if (pixel_ready) begin
               bright_d[led_sel] = decay(bright_q[led_sel]);
               if (led_is_last) begin
                  pixel_valid_d = 1'b0;
                  pixel_last_d  = 1'b0;
                  pixel_data_d  = '0;
                  led_d         = '0;
                  frame_done_d  = 1'b1;
                  state_d       = ST_DONE;
               end else begin
                  led_d        = led_nxt;
                  pixel_data_d = scl_grb;
                  pixel_last_d = (led_nxt == LAST_IDX);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         led_q         <= '0;
         rnd_ready_q   <= 1'b0;
         pixel_valid_q <= 1'b0;
         pixel_data_q  <= '0;
         pixel_last_q  <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         for (int i = 0; i < NB_LEDS; i++) begin
            bright_q[i] <= '0;
            pal_q[i]    <= '0;
         end
      end else begin
         state_q       <= state_d;
         led_q         <= led_d;
         rnd_ready_q   <= rnd_ready_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_data_q  <= pixel_data_d;
         pixel_last_q  <= pixel_last_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
         bright_q      <= bright_d;
         pal_q         <= pal_d;
      end
   end

   assign rnd_ready   = rnd_ready_q;
   assign pixel_valid = pixel_valid_q;
   assign pixel_data  = pixel_data_q;
   assign pixel_last  = pixel_last_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_twinkle_sequencer.sv
// Directed bench for twinkle_sequencer: ignition, decay, range rejection,
// back-pressure, ignored starts and asynchronous reset.
module tb_twinkle_sequencer;

   localparam int NB = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [7:0]  cfg_density;
   logic        frame_start;
   logic        rnd_valid;
   logic [31:0] rnd_data;
   logic        rnd_ready;
   logic        pixel_valid;
   logic [23:0] pixel_data;
   logic        pixel_last;
   logic        pixel_ready;
   logic        busy;
   logic        frame_done;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] got_data [NB];
   logic        got_last [NB];
   logic [23:0] exp_px   [NB];

   always #5 clk = ~clk;

   twinkle_sequencer #(.NB_LEDS(NB), .IDX_W(8), .DECAY_SHIFT(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .cfg_density (cfg_density),
      .frame_start (frame_start),
      .rnd_valid   (rnd_valid),
      .rnd_data    (rnd_data),
      .rnd_ready   (rnd_ready),
      .pixel_valid (pixel_valid),
      .pixel_data  (pixel_data),
      .pixel_last  (pixel_last),
      .pixel_ready (pixel_ready),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NB; i++) exp_px[i] = 24'h0;
   endtask

   task automatic run_frame(input logic [7:0] dens, input logic [31:0] rnd,
                            input bit rand_rdy, input int seed_wait, input bit poke);
      int          hs;
      int          cyc;
      bit          stalled;
      logic [23:0] pd;
      logic        pl;
      for (int i = 0; i < NB; i++) begin
         got_data[i] = 'x;
         got_last[i] = 1'bx;
      end
      cfg_density = dens;
      enable      = 1'b1;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("seed_rnd_ready", 32'(rnd_ready), 32'd1);
      chk("seed_busy", 32'(busy), 32'd1);
      if (seed_wait > 0) begin
         repeat (seed_wait) step();
         chk("seed_hold_ready", 32'(rnd_ready), 32'd1);
         chk("seed_hold_busy", 32'(busy), 32'd1);
         chk("seed_hold_novalid", 32'(pixel_valid), 32'd0);
      end
      rnd_valid = 1'b1;
      rnd_data  = rnd;
      step();
      rnd_valid = 1'b0;
      rnd_data  = $urandom;
      chk("first_valid", 32'(pixel_valid), 32'd1);
      chk("seed_ready_drop", 32'(rnd_ready), 32'd0);
      hs      = 0;
      cyc     = 0;
      stalled = 1'b0;
      pd      = '0;
      pl      = 1'b0;
      while (hs < NB && cyc < 1000) begin
         chk("stream_valid", 32'(pixel_valid), 32'd1);
         if (stalled) begin
            chk("stall_data", 32'(pixel_data), 32'(pd));
            chk("stall_last", 32'(pixel_last), 32'(pl));
         end
         pixel_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         frame_start = poke && (cyc == 5);
         if (pixel_valid && pixel_ready) begin
            got_data[hs] = pixel_data;
            got_last[hs] = pixel_last;
            hs++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            pd      = pixel_data;
            pl      = pixel_last;
         end
         step();
         cyc++;
      end
      pixel_ready = 1'b0;
      frame_start = 1'b0;
      chk("handshakes", 32'(hs), 32'(NB));
      chk("frame_done_pulse", 32'(frame_done), 32'd1);
      chk("done_no_valid", 32'(pixel_valid), 32'd0);
      step();
      chk("frame_done_clear", 32'(frame_done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic cmp_frame(input string tag);
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("%s_px%0d", tag, i), 32'(got_data[i]), 32'(exp_px[i]));
         chk($sformatf("%s_last%0d", tag, i), 32'(got_last[i]), 32'(i == NB - 1));
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b0;
      cfg_density = 8'h00;
      frame_start = 1'b0;
      rnd_valid   = 1'b0;
      rnd_data    = 32'h0;
      pixel_ready = 1'b0;
      #1;
      chk("rst_rnd_ready", 32'(rnd_ready), 32'd0);
      chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
      chk("rst_pixel_data", 32'(pixel_data), 32'd0);
      chk("rst_pixel_last", 32'(pixel_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // density 0 never ignites
      clear_exp();
      run_frame(8'h00, 32'h0000_0000, 1'b0, 0, 1'b0);
      cmp_frame("f1_dark");

      // ignite LED 5 red at full brightness
      clear_exp();
      exp_px[5] = 24'h00FE00;
      run_frame(8'h80, 32'h0001_0510, 1'b0, 0, 1'b0);
      cmp_frame("f2_ignite");

      // thr=FF: no ignition, LED 5 shows b=E0
      exp_px[5] = 24'h00DF00;
      run_frame(8'h80, 32'h0001_05FF, 1'b0, 0, 1'b0);
      cmp_frame("f3_decay");

      // idx 0x40 out of range: LED 0 stays dark, LED 5 at b=C4
      exp_px[5] = 24'h00C300;
      run_frame(8'h80, 32'h0000_4010, 1'b0, 0, 1'b0);
      cmp_frame("f4_range");

      // back-pressure, long SEED wait, ignored start; ignite LED 31 green
      exp_px[5]  = 24'h00AB00;
      exp_px[31] = 24'hFE0000;
      run_frame(8'h80, 32'h0002_1F05, 1'b1, 50, 1'b1);
      cmp_frame("f5_stall");
      step();
      chk("poke_no_frame_ready", 32'(rnd_ready), 32'd0);
      chk("poke_no_frame_busy", 32'(busy), 32'd0);

      // frame_start with enable low
      enable      = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("dis_rnd_ready", 32'(rnd_ready), 32'd0);
      chk("dis_busy", 32'(busy), 32'd0);
      step();
      chk("dis_busy_later", 32'(busy), 32'd0);
      enable = 1'b1;

      // ignite LED 2 gold, then reset asynchronously mid-stream
      cfg_density = 8'h80;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      rnd_valid   = 1'b1;
      rnd_data    = 32'h0003_0201;
      pixel_ready = 1'b1;
      step();
      rnd_valid = 1'b0;
      step();
      step();
      chk("gold_px2", 32'(pixel_data), 32'h00BFFE00);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_pixel_valid", 32'(pixel_valid), 32'd0);
      chk("arst_pixel_data", 32'(pixel_data), 32'd0);
      chk("arst_pixel_last", 32'(pixel_last), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rnd_ready", 32'(rnd_ready), 32'd0);
      chk("arst_frame_done", 32'(frame_done), 32'd0);
      pixel_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_frame_done", 32'(frame_done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);

      // brightness must have been cleared by reset
      clear_exp();
      run_frame(8'h00, 32'h0000_0000, 1'b0, 0, 1'b0);
      cmp_frame("f7_cleared");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
